// File: rtl/sfu_pkg.sv
// Shared SFU definitions: bundle geometry, FSM state type, partial-sum type,
// ReLU and output-address helpers. Also imported by the SFU row.
package sfu_pkg;

  localparam int COL       = 8;   // output channels per word
  localparam int MIJ_LEN   = 16;  // output pixels per bundle
  localparam int PSUM_BW   = 16;  // signed partial-sum width
  localparam int TILE_NUM  = 4;   // bundles per layer before the tile wraps
  localparam int ADDR_BW   = $clog2(TILE_NUM * MIJ_LEN);
  localparam int M_BW      = $clog2(MIJ_LEN);
  localparam int T_BW      = $clog2(TILE_NUM);
  localparam int BUNDLE_BW = COL * MIJ_LEN * PSUM_BW;
  localparam int WORD_BW   = COL * PSUM_BW;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  typedef logic signed [PSUM_BW-1:0] psum_t;

  // Clamp negatives to zero using the sign bit only; width is unchanged.
  function automatic psum_t relu(input psum_t x);
    return x[PSUM_BW-1] ? psum_t'(0) : x;
  endfunction

  // Output SRAM address of pixel m within the given tile.
  function automatic logic [ADDR_BW-1:0] tile_addr(input logic [T_BW-1:0] tile,
                                                    input logic [M_BW-1:0] m);
    return ADDR_BW'(int'(tile) * MIJ_LEN + int'(m));
  endfunction

endpackage

// File: rtl/sfu_out_drain_if.sv
// Bundle input and output-SRAM write port of the SFU output drain.
// The master side is the drain itself; the slave side is the SFU row plus SRAM.
interface sfu_out_drain_if;
  import sfu_pkg::*;

  logic [BUNDLE_BW-1:0] in;
  logic                 i_valid;
  logic                 relu_en;
  logic                 mem_ready;
  logic                 mem_wen;
  logic [ADDR_BW-1:0]   mem_addr;
  logic [WORD_BW-1:0]   mem_data;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  modport master (
    input  in, i_valid, relu_en, mem_ready,
    output mem_wen, mem_addr, mem_data, busy, done, overrun
  );

  modport slave (
    output in, i_valid, relu_en, mem_ready,
    input  mem_wen, mem_addr, mem_data, busy, done, overrun
  );

endinterface

// File: rtl/sfu_word_mux.sv
// Selects output word m from a column-major bundle, transposing it to
// pixel-major order (channel j of the word is element (j,m)), with optional ReLU.
module sfu_word_mux
  import sfu_pkg::*;
(
  input  logic [BUNDLE_BW-1:0] bundle_i,
  input  logic [M_BW-1:0]      m_i,
  input  logic                 relu_en_i,
  output logic [WORD_BW-1:0]   word_o
);

  // Gather element (j,m) for every channel j into one word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    word_o = '0;
    for (int j = 0; j < COL; j++) begin
      word_o[j*PSUM_BW +: PSUM_BW] = relu_en_i
        ? relu(psum_t'(bundle_i[(j*MIJ_LEN + int'(m_i))*PSUM_BW +: PSUM_BW]))
        : bundle_i[(j*MIJ_LEN + int'(m_i))*PSUM_BW +: PSUM_BW];
    end
  end

endmodule

// File: rtl/sfu_out_drain.sv
// SFU row output drain: captures a bundle on a rising i_valid, then writes its
// mij_len transposed words to the output SRAM under a ready/enable handshake,
// advancing a wrapping tile address after every bundle.
module sfu_out_drain
  import sfu_pkg::*;
(
  input logic             clk,
  input logic             reset,
  sfu_out_drain_if.master bus
);

  state_e               state_q, state_d;
  logic                 valid_q;
  logic [BUNDLE_BW-1:0] buf_q, buf_d;
  logic                 relu_q, relu_d;
  logic [M_BW-1:0]      m_q, m_d;
  logic [T_BW-1:0]      tile_q, tile_d;
  logic [ADDR_BW-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_BW-1:0]   mem_data_q, mem_data_d;
  logic                 overrun_q, overrun_d;

  logic                 capture;
  logic                 accept;
  logic                 last_word;
  logic [BUNDLE_BW-1:0] mux_bundle;
  logic [M_BW-1:0]      mux_m;
  logic                 mux_relu;
  logic [WORD_BW-1:0]   mux_word;

  assign capture   = bus.i_valid & ~valid_q;
  assign accept    = (state_q == DRAIN) & bus.mem_ready;
  assign last_word = (m_q == M_BW'(MIJ_LEN - 1));

  // The mux prepares the word that will be presented next cycle: word 0 of the
  // incoming bundle while idle, otherwise word m+1 of the held buffer.
  assign mux_bundle = (state_q == IDLE) ? bus.in      : buf_q;
  assign mux_relu   = (state_q == IDLE) ? bus.relu_en : relu_q;
  assign mux_m      = (state_q == DRAIN) ? m_q + M_BW'(1) : '0;

  sfu_word_mux u_word_mux (
    .bundle_i  (mux_bundle),
    .m_i       (mux_m),
    .relu_en_i (mux_relu),
    .word_o    (mux_word)
  );

  // Next-state logic: FSM transitions, counters, output word/address, overrun.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    relu_d     = relu_q;
    m_d        = m_q;
    tile_d     = tile_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    overrun_d  = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d    = DRAIN;
          buf_d      = bus.in;
          relu_d     = bus.relu_en;
          m_d        = '0;
          mem_addr_d = tile_addr(tile_q, '0);
          mem_data_d = mux_word;
        end
      end
      DRAIN: begin
        if (capture) overrun_d = 1'b1;
        if (accept) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            m_d        = mux_m;
            mem_addr_d = tile_addr(tile_q, mux_m);
            mem_data_d = mux_word;
          end
        end
      end
      DONE: begin
        if (capture) overrun_d = 1'b1;
        tile_d  = (tile_q == T_BW'(TILE_NUM - 1)) ? '0 : tile_q + T_BW'(1);
        m_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      relu_q     <= 1'b0;
      m_q        <= '0;
      tile_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      valid_q    <= bus.i_valid;
      relu_q     <= relu_d;
      m_q        <= m_d;
      tile_q     <= tile_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      overrun_q  <= overrun_d;
    end
  end

  // Bundle buffer, loaded only on capture.
  // NOTE: the buffer has no reset; it is always written before it is read, so a reset would only cost area.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.mem_wen  = (state_q == DRAIN);
  assign bus.busy     = (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sfu_out_drain.sv
// Self-checking bench for sfu_out_drain: a transaction-level model predicts the
// write stream per bundle; a compare process checks outputs every cycle, and
// directed scenarios pin timing and values with hand-computed expectations.
module tb_sfu_out_drain;
  import sfu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfu_out_drain_if dif ();

  sfu_out_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ADDR_BW-1:0] addr;
    logic [WORD_BW-1:0] data;
  } wr_t;

  wr_t exp_q[$];   // writes the model still expects for the bundle in flight
  wr_t log_q[$];   // writes the DUT actually had accepted
  bit  m_done, m_ovr, m_prev;
  int  m_tile;
  int  cyc = 0;
  int  cap_cyc, done_cyc, done_cnt;

  // Word m of a bundle straight from the element layout, with ReLU as a sign test.
  function automatic logic [WORD_BW-1:0] model_word(input logic [BUNDLE_BW-1:0] b,
                                                     input int m, input bit r);
    logic [WORD_BW-1:0] w;
    w = '0;
    for (int j = 0; j < COL; j++) begin
      int e;
      e = $signed(b[(j*MIJ_LEN + m)*PSUM_BW +: PSUM_BW]);
      if (r && e < 0) e = 0;
      w[j*PSUM_BW +: PSUM_BW] = e[PSUM_BW-1:0];
    end
    return w;
  endfunction

  // Model update and write log, on the active edge using pre-edge values.
  always @(posedge clk) begin : model
    bit cap, active, new_done;
    if (dif.mem_wen && dif.mem_ready) log_q.push_back('{dif.mem_addr, dif.mem_data});
    if (dif.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset) begin
      exp_q.delete();
      m_done = 0;
      m_ovr  = 0;
      m_tile = 0;
      m_prev = 0;
    end else begin
      cap      = dif.i_valid && !m_prev;
      m_prev   = dif.i_valid;
      active   = (exp_q.size() > 0) || m_done;
      new_done = 0;
      if (exp_q.size() > 0 && dif.mem_ready) begin
        exp_q.delete(0);
        if (exp_q.size() == 0) new_done = 1;
      end
      if (m_done) m_tile = (m_tile + 1) % TILE_NUM;
      if (cap) begin
        if (active) m_ovr = 1;
        else begin
          cap_cyc = cyc;
          for (int m = 0; m < MIJ_LEN; m++)
            exp_q.push_back('{ADDR_BW'(m_tile * MIJ_LEN + m), model_word(dif.in, m, dif.relu_en)});
        end
      end
      m_done = new_done;
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("mem_wen", dif.mem_wen, exp_q.size() > 0);
    check("busy", dif.busy, exp_q.size() > 0);
    check("done", dif.done, m_done);
    check("overrun", dif.overrun, m_ovr);
    if (exp_q.size() > 0) begin
      check("mem_addr", dif.mem_addr, exp_q[0].addr);
      check("mem_data", dif.mem_data, exp_q[0].data);
    end
  end

  logic [BUNDLE_BW-1:0] bund;

  task automatic put(input int j, input int m, input int v);
    bund[(j*MIJ_LEN + m)*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
  endtask

  task automatic rand_bundle();
    for (int i = 0; i < BUNDLE_BW/32; i++) bund[i*32 +: 32] = $urandom();
    dif.in      = bund;
    dif.relu_en = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse();
    @(negedge clk);
    dif.i_valid = 1'b1;
    @(negedge clk);
    dif.i_valid = 1'b0;
  endtask

  // Wait for done; optionally randomise ready and inject stray i_valid rises.
  task automatic wait_done(input bit rnd, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dif.done) begin
        got = 1;
        break;
      end
      if (rnd) begin
        dif.mem_ready = ($urandom_range(0, 3) != 0);
        dif.i_valid   = ($urandom_range(0, 15) == 0);
      end
    end
    dif.mem_ready = 1'b1;
    dif.i_valid   = 1'b0;
    check("drain_done_seen", got, 1'b1);
  endtask

  logic [WORD_BW-1:0] w;
  int bases[5] = '{0, 16, 32, 48, 0};

  initial begin
    reset         = 1'b1;
    dif.in        = '0;
    dif.i_valid   = 1'b0;
    dif.relu_en   = 1'b0;
    dif.mem_ready = 1'b1;
    bund          = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_wen", dif.mem_wen, 1'b0);
    check("rst_mem_addr", dif.mem_addr, '0);
    check("rst_mem_data", dif.mem_data, '0);
    check("rst_busy", dif.busy, 1'b0);
    check("rst_done", dif.done, 1'b0);
    check("rst_overrun", dif.overrun, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic drain: element (j,m) = m*16+j, ReLU off, ready tied high.
    log_q.delete();
    done_cnt = 0;
    for (int j = 0; j < COL; j++)
      for (int m = 0; m < MIJ_LEN; m++) put(j, m, m*16 + j);
    dif.in = bund;
    dif.relu_en = 1'b0;
    pulse();
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    check("t1_nwrites", log_q.size(), 16);
    for (int m = 0; m < MIJ_LEN; m++) begin
      w = '0;
      for (int j = 0; j < COL; j++) w[j*PSUM_BW +: PSUM_BW] = 16'(m*16 + j);
      check("t1_addr", log_q[m].addr, m);
      check("t1_data", log_q[m].data, w);
    end
    check("t1_done_latency", done_cyc - cap_cyc, 17);
    check("t1_done_count", done_cnt, 1);

    // ReLU on: odd channels -1, even +5.
    log_q.delete();
    for (int j = 0; j < COL; j++)
      for (int m = 0; m < MIJ_LEN; m++) put(j, m, (j % 2) ? -1 : 5);
    dif.in = bund;
    dif.relu_en = 1'b1;
    pulse();
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    check("t2_relu_w0", log_q[0].data, 128'h0000_0005_0000_0005_0000_0005_0000_0005);
    check("t2_relu_w15", log_q[15].data, 128'h0000_0005_0000_0005_0000_0005_0000_0005);
    check("t2_base", log_q[0].addr, 16);

    // Same bundle, ReLU off: odd channels pass through as 0xFFFF.
    log_q.delete();
    dif.relu_en = 1'b0;
    pulse();
    wait_done(0, 40);
    repeat (2) @(negedge clk);
    check("t2_norelu_w3", log_q[3].data, 128'hFFFF_0005_FFFF_0005_FFFF_0005_FFFF_0005);
    check("t2_norelu_base", log_q[0].addr, 32);

    // Backpressure: ready low for 3 cycles while word 4 is presented.
    begin
      int hold, stall_left;
      bit got;
      log_q.delete();
      rand_bundle();
      pulse();
      hold = 0; stall_left = -1; got = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (dif.done) begin
          got = 1;
          break;
        end
        if (dif.mem_wen && dif.mem_addr == 6'd52) hold++;
        if (stall_left < 0 && dif.mem_wen && dif.mem_addr == 6'd52) stall_left = 3;
        if (stall_left > 0) begin
          dif.mem_ready = 1'b0;
          stall_left--;
        end else dif.mem_ready = 1'b1;
      end
      dif.mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t3_done_seen", got, 1'b1);
      check("t3_hold_cycles", hold, 4);
      check("t3_done_latency", done_cyc - cap_cyc, 20);
      check("t3_nwrites", log_q.size(), 16);
      for (int i = 0; i < MIJ_LEN; i++) check("t3_addr_seq", log_q[i].addr, 48 + i);
    end

    // Tile wrap with i_valid held high for 40 cycles per bundle.
    for (int b = 0; b < 5; b++) begin
      log_q.delete();
      done_cnt = 0;
      rand_bundle();
      @(negedge clk);
      dif.i_valid = 1'b1;
      repeat (40) @(negedge clk);
      dif.i_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_base", log_q[0].addr, bases[b]);
      check("t4_nwrites", log_q.size(), 16);
      check("t4_one_capture", done_cnt, 1);
    end

    // Overrun: second rise five cycles after the first capture.
    log_q.delete();
    done_cnt = 0;
    rand_bundle();
    pulse();
    repeat (4) @(negedge clk);
    dif.i_valid = 1'b1;
    @(negedge clk);
    dif.i_valid = 1'b0;
    wait_done(0, 40);
    check("t5_overrun_set", dif.overrun, 1'b1);
    repeat (6) @(negedge clk);
    check("t5_overrun_sticky", dif.overrun, 1'b1);
    check("t5_nwrites", log_q.size(), 16);
    check("t5_first_addr", log_q[0].addr, 16);
    check("t5_last_addr", log_q[15].addr, 31);
    check("t5_done_count", done_cnt, 1);

    // Reset while word 7 of a tile-2 bundle is presented.
    begin
      bit reached;
      reached = 0;
      rand_bundle();
      pulse();
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (dif.mem_wen && dif.mem_addr == 6'd39) begin
          reached = 1;
          break;
        end
      end
      check("t6_reached_m7", reached, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("t6_mem_wen", dif.mem_wen, 1'b0);
      check("t6_mem_addr", dif.mem_addr, '0);
      check("t6_mem_data", dif.mem_data, '0);
      check("t6_busy", dif.busy, 1'b0);
      check("t6_done", dif.done, 1'b0);
      check("t6_overrun", dif.overrun, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      log_q.delete();
      rand_bundle();
      pulse();
      wait_done(0, 40);
      repeat (2) @(negedge clk);
      check("t6_restart_addr", log_q[0].addr, 0);
      check("t6_restart_nwrites", log_q.size(), 16);
    end

    // Randomised traffic: random data, ReLU, ready and stray valid rises.
    for (int it = 0; it < 25; it++) begin
      rand_bundle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse();
      wait_done(1, 200);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
